// File: rtl/wb_arb_sched_if.sv
// wb_arb_sched_if: bundle of master requests, slave responses and scheduler controls
//   wbm_cyc_i/wbm_stb_i : per-master cycle/strobe requests
//   wbs_ack_i/err_i/rty_i: slave responses
//   grant_o, master_sel_o, active_o, wbm_abort_err_o, abort_cnt_o: scheduler outputs
//   modport slave  : seen by the scheduler
//   modport master : seen by the requesting side / bench
interface wb_arb_sched_if #(
    parameter int num_masters = 4,
    parameter int master_sel_bits = num_masters > 1 ? $clog2(num_masters) : 1
);
    logic [num_masters-1:0] wbm_cyc_i;
    logic [num_masters-1:0] wbm_stb_i;
    logic wbs_ack_i;
    logic wbs_err_i;
    logic wbs_rty_i;
    logic [num_masters-1:0] grant_o;
    logic [master_sel_bits-1:0] master_sel_o;
    logic active_o;
    logic [num_masters-1:0] wbm_abort_err_o;
    logic [7:0] abort_cnt_o;
    modport slave (
        input wbm_cyc_i, wbm_stb_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        output grant_o, master_sel_o, active_o, wbm_abort_err_o, abort_cnt_o
    );
    modport master (
        output wbm_cyc_i, wbm_stb_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
        input grant_o, master_sel_o, active_o, wbm_abort_err_o, abort_cnt_o
    );
endinterface

// File: rtl/wb_arb_sched.sv
// wb_arb_sched: round-robin, burst-locked grant scheduler with slave watchdog
//   wb_clk_i  : clock
//   wb_rst_ni : asynchronous active-low reset
//   bus       : requests/responses in, grant/select/active/abort-err/abort-count out
module wb_arb_sched #(
    parameter int num_masters = 4,
    parameter int timeout = 256,
    parameter int master_sel_bits = num_masters > 1 ? $clog2(num_masters) : 1
) (
    input logic wb_clk_i,
    input logic wb_rst_ni,
    wb_arb_sched_if.slave bus
);
    localparam int cw = timeout > 0 ? $clog2(timeout + 1) : 1;
    typedef enum logic [1:0] {st_idle, st_busy, st_abort} state_t;
    state_t state;
    logic [master_sel_bits-1:0] last, pick, idx, sel;
    logic [cw-1:0] cnt;
    logic any_req, resp, cyc_sel, stb_sel;
    assign any_req = |bus.wbm_cyc_i;
    assign resp = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
    // grant stays one-hot on the owner in BUSY/ABORT, so it doubles as the select mask
    assign cyc_sel = |(bus.wbm_cyc_i & bus.grant_o);
    assign stb_sel = |(bus.wbm_stb_i & bus.grant_o);
    assign bus.master_sel_o = sel;
    // scan last+N down to last+1 so the nearest requester after last wins
    always_comb begin
        pick = '0;
        idx = '0;
        for (int i = num_masters; i >= 1; i--) begin
            idx = master_sel_bits'((int'(last) + i) % num_masters);
            if (|(bus.wbm_cyc_i & (num_masters'(1) << idx))) pick = idx;
        end
    end
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= st_idle;
            bus.grant_o <= '0;
            sel <= '0;
            bus.active_o <= 1'b0;
            bus.wbm_abort_err_o <= '0;
            bus.abort_cnt_o <= '0;
            cnt <= '0;
            last <= master_sel_bits'(num_masters - 1);
        end else begin
            bus.wbm_abort_err_o <= '0;
            case (state)
                st_idle: if (any_req) begin
                    state <= st_busy;
                    bus.grant_o <= num_masters'(1) << pick;
                    sel <= pick;
                    last <= pick;
                    bus.active_o <= 1'b1;
                    cnt <= '0;
                end
                st_busy: if (!cyc_sel) begin
                    state <= st_idle;
                    bus.grant_o <= '0;
                    bus.active_o <= 1'b0;
                end else if (resp || !stb_sel) begin
                    cnt <= '0;
                end else if (timeout > 0 && cnt == cw'(timeout - 1)) begin
                    state <= st_abort;
                    bus.active_o <= 1'b0;
                    bus.wbm_abort_err_o <= bus.grant_o;
                    if (bus.abort_cnt_o != 8'hff) bus.abort_cnt_o <= bus.abort_cnt_o + 8'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                st_abort: if (!cyc_sel) begin
                    state <= st_idle;
                    bus.grant_o <= '0;
                end
                default: state <= st_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arb_sched.sv
// tb_wb_arb_sched: directed checks of grant order, burst lock, watchdog and async reset
module tb_wb_arb_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int passed = 0;
    int total = 0;
    always #5 clk = ~clk;

    wb_arb_sched_if #(.num_masters(4)) bus ();
    wb_arb_sched_if #(.num_masters(1)) bus1 ();
    wb_arb_sched #(.num_masters(4), .timeout(8)) dut (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus));
    wb_arb_sched #(.num_masters(1), .timeout(0)) dut1 (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus1));

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        {bus.wbs_ack_i, bus.wbs_err_i, bus.wbs_rty_i} = '0;
        bus1.wbm_cyc_i = '0;
        bus1.wbm_stb_i = '0;
        {bus1.wbs_ack_i, bus1.wbs_err_i, bus1.wbs_rty_i} = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.grant_o, bus.master_sel_o, bus.active_o, bus.wbm_abort_err_o, bus.abort_cnt_o} !== 19'h0) begin
            $display("FAIL reset_outputs: got grant=%b sel=%0d active=%b err=%b cnt=%0d, want all 0",
                     bus.grant_o, bus.master_sel_o, bus.active_o, bus.wbm_abort_err_o, bus.abort_cnt_o);
        end else passed++;
    endtask

    task automatic test_single();
        bus.wbm_cyc_i = 4'b0100;
        @(negedge clk);
        total++;
        if ({bus.grant_o, bus.master_sel_o, bus.active_o} !== {4'b0100, 2'd2, 1'b1}) begin
            $display("FAIL single_grant: got grant=%b sel=%0d active=%b, want 0100/2/1",
                     bus.grant_o, bus.master_sel_o, bus.active_o);
        end else passed++;
        bus.wbm_cyc_i = '0;
        @(negedge clk);
        total++;
        if ({bus.grant_o, bus.master_sel_o, bus.active_o} !== {4'b0000, 2'd2, 1'b0}) begin
            $display("FAIL single_release: got grant=%b sel=%0d active=%b, want 0000/2/0",
                     bus.grant_o, bus.master_sel_o, bus.active_o);
        end else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        bus.wbm_cyc_i = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            total++;
            if ({bus.grant_o, bus.master_sel_o, bus.active_o} !== {exp_g, 2'(k % 4), 1'b1}) begin
                $display("FAIL rr_grant_%0d: got grant=%b sel=%0d active=%b, want %b/%0d/1",
                         k, bus.grant_o, bus.master_sel_o, bus.active_o, exp_g, k % 4);
            end else passed++;
            repeat (2) @(negedge clk);
            total++;
            if (bus.grant_o !== exp_g) begin
                $display("FAIL rr_hold_%0d: got grant=%b, want %b", k, bus.grant_o, exp_g);
            end else passed++;
            bus.wbm_cyc_i[k % 4] = 1'b0;
            @(negedge clk);
            total++;
            if ({bus.grant_o, bus.active_o} !== 5'b0) begin
                $display("FAIL rr_gap_%0d: got grant=%b active=%b, want 0000/0", k, bus.grant_o, bus.active_o);
            end else passed++;
            bus.wbm_cyc_i[k % 4] = 1'b1;
            @(negedge clk);
        end
        bus.wbm_cyc_i = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst_lock();
        do_reset();
        bus.wbm_cyc_i = 4'b0010;
        @(negedge clk);
        bus.wbm_cyc_i = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({bus.grant_o, bus.active_o} !== {4'b0010, 1'b1}) begin
                $display("FAIL burst_hold_%0d: got grant=%b active=%b, want 0010/1", k, bus.grant_o, bus.active_o);
            end else passed++;
        end
        bus.wbm_cyc_i = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.grant_o, bus.master_sel_o} !== {4'b0001, 2'd0}) begin
            $display("FAIL burst_next: got grant=%b sel=%0d, want 0001/0", bus.grant_o, bus.master_sel_o);
        end else passed++;
        bus.wbm_cyc_i = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        bus.wbm_cyc_i = 4'b1000;
        bus.wbm_stb_i = 4'b1000;
        @(negedge clk);
        repeat (7) @(negedge clk);
        total++;
        if ({bus.active_o, bus.wbm_abort_err_o} !== 5'b10000) begin
            $display("FAIL to_before: got active=%b err=%b, want 1/0000", bus.active_o, bus.wbm_abort_err_o);
        end else passed++;
        @(negedge clk);
        total++;
        if ({bus.grant_o, bus.active_o, bus.wbm_abort_err_o, bus.abort_cnt_o} !== {4'b1000, 1'b0, 4'b1000, 8'd1}) begin
            $display("FAIL to_abort: got grant=%b active=%b err=%b cnt=%0d, want 1000/0/1000/1",
                     bus.grant_o, bus.active_o, bus.wbm_abort_err_o, bus.abort_cnt_o);
        end else passed++;
        @(negedge clk);
        total++;
        if ({bus.grant_o, bus.active_o, bus.wbm_abort_err_o} !== {4'b1000, 1'b0, 4'b0000}) begin
            $display("FAIL to_held: got grant=%b active=%b err=%b, want 1000/0/0000",
                     bus.grant_o, bus.active_o, bus.wbm_abort_err_o);
        end else passed++;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        @(negedge clk);
        total++;
        if (bus.grant_o !== 4'b0000) begin
            $display("FAIL to_release: got grant=%b, want 0000", bus.grant_o);
        end else passed++;
        @(negedge clk);
    endtask

    task automatic test_ack_limit();
        bus.wbm_cyc_i = 4'b0001;
        bus.wbm_stb_i = 4'b0001;
        @(negedge clk);
        repeat (7) @(negedge clk);
        bus.wbs_ack_i = 1'b1;
        @(negedge clk);
        bus.wbs_ack_i = 1'b0;
        total++;
        if ({bus.active_o, bus.wbm_abort_err_o, bus.abort_cnt_o} !== {1'b1, 4'b0000, 8'd1}) begin
            $display("FAIL ack_limit: got active=%b err=%b cnt=%0d, want 1/0000/1",
                     bus.active_o, bus.wbm_abort_err_o, bus.abort_cnt_o);
        end else passed++;
        for (int k = 0; k < 4; k++) begin
            repeat (6) @(negedge clk);
            bus.wbs_ack_i = 1'b1;
            @(negedge clk);
            bus.wbs_ack_i = 1'b0;
        end
        total++;
        if ({bus.grant_o, bus.active_o, bus.abort_cnt_o} !== {4'b0001, 1'b1, 8'd1}) begin
            $display("FAIL ack_every7: got grant=%b active=%b cnt=%0d, want 0001/1/1",
                     bus.grant_o, bus.active_o, bus.abort_cnt_o);
        end else passed++;
        bus.wbm_cyc_i = '0;
        bus.wbm_stb_i = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        bus.wbm_cyc_i = 4'b0100;
        bus.wbm_stb_i = 4'b0100;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.grant_o, bus.master_sel_o, bus.active_o, bus.wbm_abort_err_o, bus.abort_cnt_o} !== 19'h0) begin
            $display("FAIL async_reset: got grant=%b sel=%0d active=%b err=%b cnt=%0d, want all 0",
                     bus.grant_o, bus.master_sel_o, bus.active_o, bus.wbm_abort_err_o, bus.abort_cnt_o);
        end else passed++;
        bus.wbm_cyc_i = 4'b0101;
        bus.wbm_stb_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.grant_o, bus.master_sel_o, bus.wbm_abort_err_o} !== {4'b0001, 2'd0, 4'b0000}) begin
            $display("FAIL async_priority: got grant=%b sel=%0d err=%b, want 0001/0/0000",
                     bus.grant_o, bus.master_sel_o, bus.wbm_abort_err_o);
        end else passed++;
        bus.wbm_cyc_i = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_master();
        do_reset();
        bus1.wbm_cyc_i = 1'b1;
        bus1.wbm_stb_i = 1'b1;
        @(negedge clk);
        total++;
        if ({bus1.grant_o, bus1.master_sel_o, bus1.active_o} !== 3'b101) begin
            $display("FAIL one_grant: got grant=%b sel=%0d active=%b, want 1/0/1",
                     bus1.grant_o, bus1.master_sel_o, bus1.active_o);
        end else passed++;
        repeat (20) @(negedge clk);
        total++;
        if ({bus1.active_o, bus1.wbm_abort_err_o, bus1.abort_cnt_o} !== {1'b1, 1'b0, 8'd0}) begin
            $display("FAIL one_no_watchdog: got active=%b err=%b cnt=%0d, want 1/0/0",
                     bus1.active_o, bus1.wbm_abort_err_o, bus1.abort_cnt_o);
        end else passed++;
        bus1.wbm_cyc_i = 1'b0;
        @(negedge clk);
        bus1.wbm_cyc_i = 1'b1;
        @(negedge clk);
        total++;
        if ({bus1.grant_o, bus1.master_sel_o, bus1.active_o} !== 3'b101) begin
            $display("FAIL one_regrant: got grant=%b sel=%0d active=%b, want 1/0/1",
                     bus1.grant_o, bus1.master_sel_o, bus1.active_o);
        end else passed++;
        bus1.wbm_cyc_i = 1'b0;
        bus1.wbm_stb_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_timeout();
        test_ack_limit();
        test_async_reset();
        test_single_master();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_arb_sched.md
# wb_arb_sched

Grant scheduler for a shared Wishbone slave port: round-robin selection among `num_masters` requesters, with grant locked for the whole bus cycle (burst-safe) and a watchdog that aborts transfers left unanswered by the slave. It drives the select/active controls of the master-to-slave mux in the interconnect and supplies the per-master error pulse on timeout.

## Interface

Parameters:
- `num_masters`, 4, number of requesting masters (≥1).
- `timeout`, 256, cycles a strobed transfer may wait for ack/err/rty before abort. 0 disables the watchdog.
- `master_sel_bits`, `num_masters>1 ? $clog2(num_masters) : 1`, select width.

Ports:
- `wb_clk_i`, in, 1, clock.
- `wb_rst_ni`, in, 1, reset. Asynchronous, active-low.
- `wbm_cyc_i`, in, num_masters, per-master cycle request.
- `wbm_stb_i`, in, num_masters, per-master strobe.
- `wbs_ack_i`, in, 1, slave ack.
- `wbs_err_i`, in, 1, slave err.
- `wbs_rty_i`, in, 1, slave retry.
- `grant_o`, out, num_masters, one-hot grant, registered.
- `master_sel_o`, out, master_sel_bits, index of granted master, registered.
- `active_o`, out, 1, slave port owned; gates slave cyc and master acks.
- `wbm_abort_err_o`, out, num_masters, one-cycle err pulse to the granted master on timeout.
- `abort_cnt_o`, out, 8, saturating count of timeout aborts.

## Operation

- State machine: IDLE, BUSY, ABORT.
- IDLE: `active_o`=0, `grant_o`=0. If any `wbm_cyc_i` bit is set, pick the first requester at index (last+1) mod N, wrapping upward. Register `grant_o`/`master_sel_o`, set `active_o`=1, update last=pick, go BUSY.
- BUSY: grant held while `wbm_cyc_i[sel]`=1, regardless of other requests. When `wbm_cyc_i[sel]`=0, go IDLE and clear `grant_o`/`active_o`. `master_sel_o` keeps its last value.
- Watchdog (BUSY only, `timeout`>0): counter width `$clog2(timeout+1)`.
  - Clears to 0 when any of `wbs_ack_i`/`wbs_err_i`/`wbs_rty_i` is asserted, or when `wbm_stb_i[sel]`=0.
  - Otherwise increments.
  - Abort condition: the counter equals `timeout`-1 and the increment condition holds.
  - On abort: go ABORT, `active_o`←0, `wbm_abort_err_o[sel]`←1 for exactly one cycle, `abort_cnt_o`++ (saturates at 255).
- ABORT: `active_o`=0, `grant_o` still held. `wbm_abort_err_o`=0 after the first cycle. Stay until `wbm_cyc_i[sel]`=0, then go IDLE.
- Response on the same cycle the counter reaches its limit: the response wins; no abort.
- Counter clears on every BUSY entry.
- `num_masters`=1: always picks master 0; `master_sel_o`=0.
- Reset values: state IDLE, `grant_o`=0, `master_sel_o`=0, `active_o`=0, `wbm_abort_err_o`=0, `abort_cnt_o`=0, counter 0, last=num_masters-1 (master 0 has first priority).
- Reset asserted mid-transfer forces all reset values immediately (asynchronous). No abort pulse is generated.

## Timing

- Request to grant: 1 cycle. `wbm_cyc_i` seen in IDLE at edge n gives `grant_o`/`active_o` valid after edge n+1.
- Release: `wbm_cyc_i[sel]` deasserted at edge n gives `active_o`=0 after edge n+1. IDLE then needs at least one cycle, so there is a minimum 1-cycle gap between consecutive grants.
- Abort: the stalled strobe must be continuously high for `timeout` cycles counted from the first strobed BUSY cycle. The err pulse and `active_o` drop occur together, registered.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan

- Reset, then single request: `wbm_cyc_i`=0b0100 → one cycle later `grant_o`=0b0100, `master_sel_o`=2, `active_o`=1. Drop cyc → `active_o`=0 next cycle.
- Round-robin fairness: hold `wbm_cyc_i`=0b1111 with each master releasing after 3 cycles → grant order 0,1,2,3,0, with a 1-cycle idle gap between grants.
- Burst lock: master 1 granted, master 0 raises cyc mid-burst → `grant_o` stays 0b0010 until master 1 drops cyc. The next grant goes to master 0.
- Timeout (`timeout`=8): granted master 3 holds stb with no response → after 8 strobed cycles, `wbm_abort_err_o`=0b1000 for one cycle, `active_o`=0, `abort_cnt_o`=1. Grant is held until cyc3 drops.
- Ack on the limit cycle (`timeout`=8): ack asserted on the 8th stalled cycle → no abort, `abort_cnt_o` unchanged. An ack every 7 cycles never aborts.
- Asynchronous reset mid-BUSY: assert `wb_rst_ni`=0 between clock edges → all outputs are 0 immediately. After release, master 0 has first priority.
